// File: rtl/tq_row_pack_pkg.sv
// Shared transform/quantisation definitions: block-size encoding, lane counts
// and size helpers used by the row packer and its neighbours.
package tq_row_pack_pkg;

  typedef enum logic [1:0] {TS_4, TS_8, TS_16, TS_32} ts_e;

  typedef enum logic {S_IDLE, S_COLLECT} rp_state_e;

  localparam int LANES    = 32;
  localparam int IN_LANES = 4;
  localparam int SLOTS    = LANES / IN_LANES;

  // Samples per row (also rows per block): 4, 8, 16 or 32.
  function automatic logic [5:0] n_of(input ts_e ts);
    return 6'd4 << ts;
  endfunction

  // Input beats needed to fill one row: 1, 2, 4 or 8.
  function automatic logic [3:0] beats_of(input ts_e ts);
    return 4'd1 << ts;
  endfunction

endpackage

// File: rtl/tq_row_pack.sv
// Collects 4-sample beats into 4/8/16/32-sample rows and emits each row as a
// 32-lane vector one cycle after its final beat; no output stall.
module tq_row_pack
  import tq_row_pack_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [1:0]                  i_transize,
  input  logic                        i_inverse,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [IN_LANES*DATA_W-1:0]  i_data,
  output logic                        o_valid,
  output logic [1:0]                  o_transize,
  output logic                        o_inverse,
  output logic [4:0]                  o_row,
  output logic                        o_last,
  output logic [LANES*DATA_W-1:0]     o_data
);

  localparam int BEAT_W = IN_LANES * DATA_W;

  rp_state_e                 r_state, w_next_state;
  ts_e                       r_ts;
  logic                      r_inv;
  logic [2:0]                r_beat_cnt;
  logic [4:0]                r_row_cnt;
  logic [BEAT_W-1:0]         r_buf [SLOTS];
  logic                      r_valid;
  logic [4:0]                r_row;
  logic                      r_last;
  logic [LANES*DATA_W-1:0]   r_data;

  logic                      w_accept;
  logic                      w_row_done;
  logic                      w_blk_done;
  logic [3:0]                w_beats;
  logic [LANES*DATA_W-1:0]   w_row;

  assign i_ready    = (r_state == S_COLLECT);
  assign w_accept   = i_valid && i_ready;
  assign w_beats    = beats_of(r_ts);
  assign w_row_done = w_accept && ({1'b0, r_beat_cnt} == w_beats - 4'd1);
  assign w_blk_done = w_row_done && ({1'b0, r_row_cnt} == n_of(r_ts) - 6'd1);

  // The final beat bypasses the buffer so the row registers on its own edge;
  // slots beyond the block size stay zero regardless of buffer contents.
  always_comb begin
    w_row = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (4'(s) < w_beats) begin
        if (3'(s) == r_beat_cnt) w_row[s*BEAT_W +: BEAT_W] = i_data;
        else                     w_row[s*BEAT_W +: BEAT_W] = r_buf[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (i_start)    w_next_state = S_COLLECT;
      S_COLLECT: if (w_blk_done) w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts       <= TS_4;
      r_inv      <= 1'b0;
      r_beat_cnt <= '0;
      r_row_cnt  <= '0;
      for (int s = 0; s < SLOTS; s++) r_buf[s] <= '0;
      r_valid    <= 1'b0;
      r_row      <= '0;
      r_last     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_IDLE && i_start) begin
        r_ts       <= ts_e'(i_transize);
        r_inv      <= i_inverse;
        r_beat_cnt <= '0;
        r_row_cnt  <= '0;
      end else if (w_accept) begin
        if (w_row_done) begin
          r_data     <= w_row;
          r_valid    <= 1'b1;
          r_row      <= r_row_cnt;
          r_last     <= w_blk_done;
          r_beat_cnt <= '0;
          r_row_cnt  <= r_row_cnt + 5'd1;
          for (int s = 0; s < SLOTS; s++) r_buf[s] <= '0;
        end else begin
          r_buf[r_beat_cnt] <= i_data;
          r_beat_cnt        <= r_beat_cnt + 3'd1;
        end
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_transize = r_ts;
  assign o_inverse  = r_inv;
  assign o_row      = r_row;
  assign o_last     = r_last;
  assign o_data     = r_data;

endmodule

// File: tb/tb_tq_row_pack.sv
// Randomized bench for tq_row_pack: a row-level model predicts every output
// pulse (content, index, flags and exact cycle) and a monitor checks them.
module tb_tq_row_pack;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic [1:0]      i_transize = '0;
  logic            i_inverse = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready;
  logic [4*DW-1:0] i_data = '0;
  logic            o_valid;
  logic [1:0]      o_transize;
  logic            o_inverse;
  logic [4:0]      o_row;
  logic            o_last;
  logic [32*DW-1:0] o_data;

  tq_row_pack #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_transize(i_transize), .i_inverse(i_inverse),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_transize(o_transize), .o_inverse(o_inverse),
    .o_row(o_row), .o_last(o_last), .o_data(o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    int           row;
    bit           last;
    int           ts;
    bit           inv;
    longint       due;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every negedge: a pulse must appear exactly on the cycle the model predicts.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check_eq("valid_at_due", 512'(o_valid), 512'(1));
        check_eq("row_data",     o_data, exp_q[0].data);
        check_eq("row_index",    512'(o_row), 512'(exp_q[0].row));
        check_eq("row_last",     512'(o_last), 512'(exp_q[0].last));
        check_eq("row_transize", 512'(o_transize), 512'(exp_q[0].ts));
        check_eq("row_inverse",  512'(o_inverse), 512'(exp_q[0].inv));
        void'(exp_q.pop_front());
      end else begin
        check_eq("no_pulse", 512'(o_valid), 512'(0));
      end
    end
  end

  // Caller sits at a negedge with the packer idle.
  task automatic start_blk(input int ts, input bit inv);
    check_eq("ready_idle", 512'(i_ready), 512'(0));
    i_start = 1'b1; i_transize = 2'(ts); i_inverse = inv;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // mode 0: random lanes, 1: row*32+lane, 2: row*N+lane+1
  // gap 0: none, 1: idle cycle before every beat but the first, 2: random idles
  task automatic run_block(input int ts, input bit inv, input int mode, input int gap,
                           input int start_beat, input bit start_last);
    int n, b, idx;
    logic [15:0] lanes [32];
    logic [63:0] d;
    exp_t e;
    n = 4 << ts;
    b = 1 << ts;
    start_blk(ts, inv);
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < 32; k++) lanes[k] = '0;
      for (int bt = 0; bt < b; bt++) begin
        idx = r * b + bt;
        if ((gap == 1 && idx > 0) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
          i_valid = 1'b0;
          i_data  = 64'($urandom);
          @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
          int lane;
          lane = 4 * bt + j;
          if (mode == 1)      lanes[lane] = 16'(r * 32 + lane);
          else if (mode == 2) lanes[lane] = 16'(r * n + lane + 1);
          else                lanes[lane] = 16'($urandom);
          d[16*j +: 16] = lanes[lane];
        end
        i_valid = 1'b1;
        i_data  = d;
        if (idx == start_beat || (start_last && r == n - 1 && bt == b - 1)) begin
          i_start = 1'b1; i_transize = 2'd0; i_inverse = ~inv;
        end
        check_eq("ready_collect", 512'(i_ready), 512'(1));
        if (bt == b - 1) begin
          e.data = '0;
          for (int k = 0; k < 32; k++) if (k < n) e.data[16*k +: 16] = lanes[k];
          e.row  = r;
          e.last = (r == n - 1);
          e.ts   = ts;
          e.inv  = inv;
          e.due  = cyc + 1;
          exp_q.push_back(e);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b0;
      end
    end
    check_eq("ready_after_block", 512'(i_ready), 512'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},    512'(i_ready), 512'(0));
    check_eq({tag, "_valid"},    512'(o_valid), 512'(0));
    check_eq({tag, "_transize"}, 512'(o_transize), 512'(0));
    check_eq({tag, "_inverse"},  512'(o_inverse), 512'(0));
    check_eq({tag, "_row"},      512'(o_row), 512'(0));
    check_eq({tag, "_last"},     512'(o_last), 512'(0));
    check_eq({tag, "_data"},     o_data, 512'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Beats offered while idle must be refused and produce nothing.
    i_valid = 1'b1;
    i_data  = {4{16'hAAAA}};
    for (int c = 0; c < 4; c++) begin
      check_eq("idle_refuses", 512'(i_ready), 512'(0));
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_data  = '0;

    run_block(0, 1'b0, 2, 0, -1, 1'b0);   // 4x4 with beats 1..16
    run_block(3, 1'b0, 1, 0, -1, 1'b0);   // 32x32 indexed pattern
    run_block(1, 1'b0, 1, 0, -1, 1'b0);   // 8x8 gap-free
    run_block(1, 1'b0, 1, 1, -1, 1'b0);   // 8x8 alternate-cycle gaps
    run_block(2, 1'b0, 0, 2, 37, 1'b1);   // 16x16, stray starts mid-block and on last beat

    // Reset three beats into a 32x32 row.
    start_blk(3, 1'b1);
    for (int bt = 0; bt < 3; bt++) begin
      i_valid = 1'b1;
      i_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrow_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_block(0, 1'b0, 0, 0, -1, 1'b0);   // clean rows after the reset

    run_block(1, 1'b1, 0, 2, -1, 1'b0);   // inverse block
    run_block(0, 1'b0, 0, 0, -1, 1'b0);   // flag returns to 0

    repeat (4) @(negedge clk);
    check_eq("pending_pulses", 512'(exp_q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tq_row_pack.md
# tq_row_pack

Row packer for the transform/quantisation datapath. It collects residual samples arriving four per cycle and assembles them into full rows of 4, 8, 16 or 32 samples. Each complete row goes out as a 32-lane vector with a single-cycle valid. It is the producer for the first butterfly/permute stage, which consumes 32 parallel 16-bit lanes plus valid, transform size and inverse flag, and applies no backpressure.

## Interface
Parameters:
- DATA_W, 16, sample width in bits (signed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  block-start pulse; samples i_transize and i_inverse.
- i_transize  in  2  0=4x4, 1=8x8, 2=16x16, 3=32x32; valid with i_start.
- i_inverse  in  1  inverse-transform flag; valid with i_start.
- i_valid  in  1  input beat valid.
- i_ready  out  1  beat accepted when i_valid && i_ready.
- i_data  in  4*DATA_W  four samples; sample j at [DATA_W*j +: DATA_W].
- o_valid  out  1  row valid, single-cycle pulse.
- o_transize  out  2  latched block size, held for the whole block.
- o_inverse  out  1  latched inverse flag, held for the whole block.
- o_row  out  5  row index within the block, 0..N-1.
- o_last  out  1  high with o_valid on the final row of a block.
- o_data  out  32*DATA_W  lane k at [DATA_W*k +: DATA_W].

## Operation
- N = 4 << transize.
- Beats per row B = 1 << transize.
- Rows per block = N.
- State machine with two states, IDLE and COLLECT.
- IDLE:
  - i_ready=0; i_valid is ignored.
  - i_start latches size and inverse, clears beat_cnt and row_cnt, and moves to COLLECT.
- COLLECT:
  - i_ready=1.
  - Each accepted beat writes lanes 4*beat_cnt .. 4*beat_cnt+3 of the assembly buffer.
  - i_start is ignored.
- When beat_cnt == B-1 on an accepted beat:
  - Register the full row into o_data. Lanes N..31 are forced to 0.
  - Pulse o_valid; o_row = row_cnt.
  - Clear the assembly buffer and beat_cnt; increment row_cnt.
- When row_cnt == N-1 on that beat: o_last=1 with the pulse, then return to IDLE.
- o_data, o_row and o_last hold between pulses. o_last clears on the next o_valid.
- Samples pass through unmodified; no arithmetic or width change.
- Gaps in i_valid are allowed at any point; counters hold while no beat is accepted.

## Timing
- Reset values:
  - state=IDLE; i_ready=0.
  - o_valid=0, o_transize=0, o_inverse=0, o_row=0, o_last=0, o_data=0.
  - Counters and assembly buffer are 0.
- Latency: o_valid is asserted exactly one cycle after the accepting edge of the row's final beat.
- Throughput:
  - One beat per cycle with no bubbles inside a block.
  - One dead cycle between blocks: return to IDLE, then i_start.
  - An i_start coincident with the last beat is ignored.
- Reset mid-block: the partial row is discarded, no o_valid is emitted, and the block returns to IDLE.
- The output has no stall; the downstream stage must accept every pulse.

## Structure
- Shared tq package holds:
  - the transform-size enum (TS_4, TS_8, TS_16, TS_32);
  - constants LANES=32 and IN_LANES=4;
  - helper functions n_of(ts) and beats_of(ts).
- Single module; no sub-module is needed.
- Assembly buffer is 8 slots of 4 lanes, indexed by beat_cnt.

## Test plan
- 4x4 block:
  - Stimulus: start ts=0, then beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} back-to-back.
  - Response: 4 pulses, each one cycle after its beat; lanes 0-3 match the beat; lanes 4-31 = 0; o_row 0..3; o_last only on row 3.
- 32x32 block:
  - Stimulus: start ts=3; lane value = row*32+lane.
  - Response: 32 pulses spaced 8 cycles apart; o_data lanes match exactly; o_last on row 31; o_transize=3 throughout.
- Gapped input:
  - Stimulus: 8x8 block with i_valid low every other cycle.
  - Response: pulses every 4 cycles; row contents unchanged versus the gap-free run.
- Protocol guards:
  - Stimulus: i_valid=1 with data 0xAAAA in IDLE.
  - Response: i_ready=0 and no output.
  - Stimulus: i_start with ts=0 mid 16x16 block.
  - Response: ignored; block completes with 16 rows and o_transize=2.
- Reset mid-row:
  - Stimulus: assert rst after 3 of 8 beats of a 32x32 row.
  - Response: all outputs 0 and no pulse; a new 4x4 block afterwards produces clean rows with lanes 4-31 = 0.
- Inverse flag:
  - Stimulus: start with i_inverse=1 and ts=1.
  - Response: o_inverse=1 on all 8 rows; it returns to the new block's value after the next i_start.
